// File: rtl/ccff_chain_loader.sv
// Streams configuration words into NUM_CHAINS fabric config chains, generating prog_clk
// from clk, and returns the bits shifted out of ccff_tail as a readback word stream.
module ccff_chain_loader #(
    parameter int NUM_CHAINS = 1,
    parameter int CHAIN_LEN  = 64,
    parameter int DATA_W     = 8,
    parameter int PROG_DIV   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  prog_clk,
    output logic [NUM_CHAINS-1:0] ccff_head,
    input  logic [NUM_CHAINS-1:0] ccff_tail,
    output logic [DATA_W-1:0]     rb_data,
    output logic                  rb_valid,
    input  logic                  rb_ready,
    output logic                  busy,
    output logic                  done
);
    localparam int BPW    = DATA_W / NUM_CHAINS;
    localparam int STEP_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int BIT_W  = $clog2(CHAIN_LEN + 1);
    localparam int DIV_W  = (PROG_DIV > 1) ? $clog2(PROG_DIV) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, LOW, HIGH, DRAIN} state_t;

    state_t                  state, state_nxt;
    logic [DIV_W-1:0]        div_cnt;
    logic [STEP_W-1:0]       step;
    logic [BIT_W-1:0]        bit_cnt;
    logic [DATA_W-1:0]       word;
    logic [DATA_W-1:0]       rb_word;
    logic [NUM_CHAINS-1:0]   head_q;
    logic                    prog_q, busy_q, done_q;
    logic                    div_last, word_end, load_end;
    logic [BIT_W-1:0]        bit_inc;

    // Chain c takes bit s*NUM_CHAINS+c of the word at shift step s.
    function automatic logic [NUM_CHAINS-1:0] map_bits(input logic [DATA_W-1:0] w,
                                                       input logic [STEP_W-1:0] s);
        int si;
        si = int'(s);
        for (int c = 0; c < NUM_CHAINS; c++) map_bits[c] = w[si*NUM_CHAINS + c];
    endfunction

    assign div_last = (div_cnt == DIV_W'(PROG_DIV - 1));
    assign bit_inc  = bit_cnt + 1'b1;
    assign word_end = (bit_inc == BIT_W'(CHAIN_LEN)) || (step == STEP_W'(BPW - 1));
    assign load_end = (bit_cnt == BIT_W'(CHAIN_LEN));

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        rb_valid  = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = LOW;
            end
            LOW:   if (div_last) state_nxt = HIGH;
            HIGH:  if (div_last) state_nxt = word_end ? DRAIN : LOW;
            DRAIN: begin
                rb_valid = 1'b1;
                if (rb_ready) state_nxt = load_end ? IDLE : FETCH;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            div_cnt <= '0;
            step    <= '0;
            bit_cnt <= '0;
            word    <= '0;
            rb_word <= '0;
            head_q  <= '0;
            prog_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            // Registered so prog_clk is a clean flop output toward the fabric.
            prog_q <= (state_nxt == HIGH);
            case (state)
                IDLE: if (start) begin
                    busy_q  <= 1'b1;
                    done_q  <= 1'b0;
                    bit_cnt <= '0;
                    step    <= '0;
                    div_cnt <= '0;
                end
                FETCH: if (in_valid) begin
                    word    <= in_data;
                    step    <= '0;
                    div_cnt <= '0;
                    rb_word <= '0;
                    head_q  <= map_bits(in_data, '0);
                end
                LOW: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        // Tail still holds the pre-shift bit until prog_clk rises.
                        for (int c = 0; c < NUM_CHAINS; c++)
                            rb_word[int'(step)*NUM_CHAINS + c] <= ccff_tail[c];
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (div_last) begin
                        div_cnt <= '0;
                        bit_cnt <= bit_inc;
                        if (!word_end) begin
                            step   <= step + 1'b1;
                            head_q <= map_bits(word, step + 1'b1);
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DRAIN: if (rb_ready && load_end) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign prog_clk  = prog_q;
    assign ccff_head = head_q;
    assign rb_data   = rb_word;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_ccff_chain_loader.sv
// Directed bench: 64-bit single-chain fabric model on the default instance, plus a
// 2-chain, 5-bit instance for the bit-mapping and partial-word cases.
module tb_ccff_chain_loader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start = 1'b0, in_valid = 1'b0, rb_ready = 1'b1;
    logic [7:0] in_data = '0;
    logic       in_ready, prog_clk, rb_valid, busy, done;
    logic [0:0] ccff_head, ccff_tail;
    logic [7:0] rb_data;

    logic       start2 = 1'b0, in_valid2 = 1'b0, rb_ready2 = 1'b1;
    logic [7:0] in_data2 = '0;
    logic       in_ready2, pc2, rb_valid2, busy2, done2;
    logic [1:0] head2;
    logic [1:0] tail2 = 2'b11;
    logic [7:0] rb_data2;

    ccff_chain_loader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .prog_clk(prog_clk), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
        .rb_data(rb_data), .rb_valid(rb_valid), .rb_ready(rb_ready), .busy(busy), .done(done)
    );

    ccff_chain_loader #(.NUM_CHAINS(2), .CHAIN_LEN(5), .DATA_W(8), .PROG_DIV(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .in_data(in_data2), .in_valid(in_valid2),
        .in_ready(in_ready2), .prog_clk(pc2), .ccff_head(head2), .ccff_tail(tail2),
        .rb_data(rb_data2), .rb_valid(rb_valid2), .rb_ready(rb_ready2), .busy(busy2), .done(done2)
    );

    // Fabric model: one 64-bit chain shifting on prog_clk, tail is the MSB.
    logic [63:0] fab = '0;
    int          edges = 0;
    always @(posedge prog_clk) begin
        fab <= {fab[62:0], ccff_head[0]};
        edges++;
    end
    assign ccff_tail[0] = fab[63];

    int busy_cyc = 0, hi_run = 0, bad_high = 0;
    always @(posedge clk) begin
        if (busy) busy_cyc++;
        if (prog_clk) hi_run++;
        else begin
            if (hi_run != 0 && hi_run != 2) bad_high++;
            hi_run = 0;
        end
    end

    logic [1:0] heads2 [8];
    int         n2 = 0;
    always @(posedge pc2) begin
        if (n2 < 8) heads2[n2] = head2;
        n2++;
    end

    int          tests = 0, fails = 0;
    logic [7:0]  wv  [8];
    logic [7:0]  rbw [8];
    logic [7:0]  rb2w[2];
    logic [63:0] snap;
    int          e0, b0, h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int n, input int gap);
        int t;
        for (int i = 0; i < n; i++) begin
            if (gap > 0 && i > 0) begin
                t = 0;
                while (!in_ready && t < 2000) begin tick(); t++; end
                for (int g = 0; g < gap; g++) begin
                    tick();
                    chk("gap_pclk_ready", 64'({prog_clk, in_ready}), 64'd1);
                end
            end
            in_data  = wv[i];
            in_valid = 1'b1;
            t = 0;
            while (!in_ready && t < 2000) begin tick(); t++; end
            chk("in_ready_wait", 64'(in_ready), 64'd1);
            tick();
            in_valid = 1'b0;
        end
    endtask

    task automatic consume(input int n, input bit hold);
        int t;
        logic [7:0] saved;
        for (int i = 0; i < n; i++) begin
            t = 0;
            while (!rb_valid && t < 2000) begin tick(); t++; end
            chk("rb_valid_wait", 64'(rb_valid), 64'd1);
            if (hold && i == 0) begin
                saved = rb_data;
                for (int s = 0; s < 20; s++) begin
                    tick();
                    chk("stall_pclk_rbv_rdy", 64'({prog_clk, rb_valid, in_ready}), 64'd2);
                    chk("stall_rb_data", 64'(rb_data), 64'(saved));
                end
                chk("stall_edges", 64'(edges - e0), 64'd8);
                rb_ready = 1'b1;
            end
            rbw[i] = rb_data;
            tick();
        end
    endtask

    task automatic do_load(input int gap, input bit hold, input bit restart);
        logic [63:0] expfab;
        logic [7:0]  expw;
        snap = fab; e0 = edges; b0 = busy_cyc; h0 = bad_high;
        rb_ready = !hold;
        start = 1'b1; tick(); start = 1'b0;
        chk("start_busy_done", 64'({busy, done}), 64'd2);
        fork
            feed(8, gap);
            consume(8, hold);
            begin
                if (restart) begin
                    repeat (60) tick();
                    start = 1'b1; tick(); start = 1'b0;
                end
            end
        join
        chk("edges", 64'(edges - e0), 64'd64);
        chk("high_phase_len", 64'(bad_high - h0), 64'd0);
        chk("end_busy_done_rbv", 64'({busy, done, rb_valid}), 64'd2);
        for (int i = 0; i < 8; i++) begin
            for (int k = 0; k < 8; k++) begin
                expw[k] = snap[63 - (8*i + k)];
                expfab[63 - (8*i + k)] = wv[i][k];
            end
            chk("rb_word", 64'(rbw[i]), 64'(expw));
        end
        chk("fabric", fab, expfab);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        logic [1:0] eh [5];
        eh = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
        repeat (3) tick();
        chk("reset_outputs", 64'({in_ready, prog_clk, ccff_head, rb_data, rb_valid, busy, done}), 64'd0);
        chk("reset_outputs2", 64'({in_ready2, pc2, head2, rb_data2, rb_valid2, busy2, done2}), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 8; i++) wv[i] = 8'(i + 1);
        do_load(0, 1'b0, 1'b0);
        chk("load_cycles_a", 64'(busy_cyc - b0), 64'd272);

        for (int i = 0; i < 8; i++) wv[i] = 8'hFF;
        do_load(0, 1'b0, 1'b1);
        chk("load_cycles_b", 64'(busy_cyc - b0), 64'd272);
        chk("rb_first_word_b", 64'(rbw[0]), 64'h01);
        chk("rb_last_word_b", 64'(rbw[7]), 64'h08);

        wv = '{8'hA5, 8'h5A, 8'hC3, 8'h3C, 8'h0F, 8'hF0, 8'h96, 8'h69};
        do_load(0, 1'b1, 1'b0);

        wv = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF1};
        do_load(10, 1'b0, 1'b0);

        // Reset in the middle of the third word's shifting.
        e0 = edges; rb_ready = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        feed(3, 0);
        t = 0;
        while ((edges - e0) < 20 && t < 500) begin tick(); t++; end
        chk("edges_before_reset", 64'(edges - e0), 64'd20);
        rst_n = 1'b0;
        #1;
        chk("mid_reset_outputs", 64'({prog_clk, busy, rb_valid, in_ready, done}), 64'd0);
        repeat (5) tick();
        chk("edges_during_reset", 64'(edges - e0), 64'd20);
        rst_n = 1'b1;
        tick();
        wv = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
        do_load(0, 1'b0, 1'b0);
        chk("load_cycles_e", 64'(busy_cyc - b0), 64'd272);

        // Two chains, five bits: one full word then a one-step partial word.
        start2 = 1'b1; tick(); start2 = 1'b0;
        fork
            begin
                for (int i = 0; i < 2; i++) begin
                    in_data2  = (i == 0) ? 8'hE4 : 8'h03;
                    in_valid2 = 1'b1;
                    t = 0;
                    while (!in_ready2 && t < 500) begin tick(); t++; end
                    chk("in_ready2_wait", 64'(in_ready2), 64'd1);
                    tick();
                    in_valid2 = 1'b0;
                end
            end
            begin
                for (int i = 0; i < 2; i++) begin
                    int u;
                    u = 0;
                    while (!rb_valid2 && u < 500) begin tick(); u++; end
                    chk("rb_valid2_wait", 64'(rb_valid2), 64'd1);
                    rb2w[i] = rb_data2;
                    tick();
                end
            end
        join
        chk("edges2", 64'(n2), 64'd5);
        for (int i = 0; i < 5; i++) chk("head_pair", 64'(heads2[i]), 64'(eh[i]));
        chk("rb2_word0", 64'(rb2w[0]), 64'hFF);
        chk("rb2_word1", 64'(rb2w[1]), 64'h03);
        chk("end2_busy_done", 64'({busy2, done2}), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
